// File: rtl/snake_game_sequencer.sv
// snake_game_sequencer: game FSM, paced move strobe, apple placement and scoring for the snake datapath.
// Optional build macro SNAKE_WALL_KILL_EN: leaving the playfield on a check cycle ends the game.
module snake_game_sequencer #(
  parameter int TICK_DIV  = 4,
  parameter int MAX_LEN   = 20,
  parameter int X_MIN     = 150,
  parameter int X_MAX     = 800,
  parameter int Y_MIN     = 34,
  parameter int Y_MAX     = 514,
  parameter int PLACE_MAX = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       up_i,
  input  logic       down_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic [9:0] head_x_i,
  input  logic [9:0] head_y_i,
  input  logic       self_hit_i,
  output logic       move_en_o,
  output logic [1:0] dir_o,
  output logic       grow_o,
  output logic [9:0] apple_x_o,
  output logic [9:0] apple_y_o,
  output logic [4:0] length_o,
  output logic [7:0] score_o,
  output logic [2:0] state_o,
  output logic       game_over_o
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int AW = $clog2(PLACE_MAX);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ATT_LAST  = AW'(PLACE_MAX - 1);
  localparam logic [9:0] AX_LO = 10'(X_MIN + 5);
  localparam logic [9:0] AX_HI = 10'(X_MAX - 5);
  localparam logic [9:0] AY_LO = 10'(Y_MIN + 5);
  localparam logic [9:0] AY_HI = 10'(Y_MAX - 5);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_PLACE = 3'b001,
    S_PLAY  = 3'b010,
    S_PAUSE = 3'b011,
    S_OVER  = 3'b100
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [AW-1:0] attempts_q, attempts_d;
  logic [1:0]    dir_q, dir_d, pend_q, pend_d;
  logic [9:0]    lfsr_x_q, lfsr_x_d, lfsr_y_q, lfsr_y_d;
  logic [9:0]    apple_x_q, apple_x_d, apple_y_q, apple_y_d;
  logic [4:0]    length_q, length_d;
  logic [7:0]    score_q, score_d;
  logic          check_q, check_d, move_en_q, move_en_d, grow_q, grow_d, game_over_q, game_over_d;
  logic          btn_vld, cand_ok, apple_hit, wall_hit;
  logic [1:0]    btn_dir;

  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[10] ? $unsigned(-d) : $unsigned(d);
  endfunction

  always_comb begin
    btn_vld = 1'b1;
    btn_dir = 2'b00;
    if (right_i)     btn_dir = 2'b00;
    else if (left_i) btn_dir = 2'b01;
    else if (up_i)   btn_dir = 2'b10;
    else if (down_i) btn_dir = 2'b11;
    else             btn_vld = 1'b0;
  end

  assign cand_ok = (lfsr_x_q >= AX_LO) && (lfsr_x_q <= AX_HI) &&
                   (lfsr_y_q >= AY_LO) && (lfsr_y_q <= AY_HI) &&
                   ((abs_diff(lfsr_x_q, head_x_i) > 11'd8) || (abs_diff(lfsr_y_q, head_y_i) > 11'd8));
  assign apple_hit = (abs_diff(head_x_i, apple_x_q) < 11'd7) && (abs_diff(head_y_i, apple_y_q) < 11'd7);

`ifdef SNAKE_WALL_KILL_EN
  assign wall_hit = (head_x_i < 10'(X_MIN)) || (head_x_i > 10'(X_MAX)) ||
                    (head_y_i < 10'(Y_MIN)) || (head_y_i > 10'(Y_MAX));
`else
  assign wall_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    attempts_d = attempts_q;
    dir_d      = dir_q;
    pend_d     = pend_q;
    check_d    = check_q;
    apple_x_d  = apple_x_q;
    apple_y_d  = apple_y_q;
    length_d   = length_q;
    score_d    = score_q;
    grow_d     = 1'b0;
    lfsr_x_d   = {lfsr_x_q[8:0], lfsr_x_q[9] ^ lfsr_x_q[6]};
    lfsr_y_d   = {lfsr_y_q[8:0], lfsr_y_q[9] ^ lfsr_y_q[6]};
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start_i) begin
          state_d    = S_PLACE;
          length_d   = 5'd1;
          score_d    = 8'd0;
          dir_d      = 2'b00;
          pend_d     = 2'b00;
          tick_d     = '0;
          check_d    = 1'b0;
          attempts_d = '0;
        end
      end
      S_PLACE: begin
        tick_d = '0;
        if (cand_ok) begin
          apple_x_d  = lfsr_x_q;
          apple_y_d  = lfsr_y_q;
          attempts_d = '0;
          state_d    = S_PLAY;
        end else if (attempts_q == ATT_LAST) begin
          apple_x_d  = score_q[0] ? 10'd650 : 10'd350;
          apple_y_d  = score_q[0] ? 10'd150 : 10'd250;
          attempts_d = '0;
          state_d    = S_PLAY;
        end else begin
          attempts_d = attempts_q + AW'(1);
        end
      end
      S_PLAY: begin
        // A reversal request against the committed heading is simply dropped.
        if (btn_vld && (btn_dir != {dir_q[1], ~dir_q[0]})) pend_d = btn_dir;
        if (move_en_q) dir_d = pend_q;
        if (check_q && (self_hit_i || wall_hit)) begin
          state_d = S_OVER;
          check_d = 1'b0;
          tick_d  = '0;
        end else if (check_q && apple_hit) begin
          state_d  = S_PLACE;
          grow_d   = 1'b1;
          score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          length_d = (length_q >= 5'(MAX_LEN)) ? length_q : length_q + 5'd1;
          check_d  = 1'b0;
          tick_d   = '0;
        end else begin
          check_d = move_en_q;
          if (pause_i) begin
            state_d = S_PAUSE;
            if (move_en_q) tick_d = '0;
          end else begin
            tick_d = move_en_q ? '0 : tick_q + TW'(1);
          end
        end
      end
      S_PAUSE: if (pause_i) state_d = S_PLAY;
      default: state_d = S_IDLE;
    endcase
    move_en_d   = (state_d == S_PLAY) && (tick_d == TICK_LAST);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      attempts_q  <= '0;
      dir_q       <= 2'b00;
      pend_q      <= 2'b00;
      check_q     <= 1'b0;
      lfsr_x_q    <= 10'h2A5;
      lfsr_y_q    <= 10'h13B;
      apple_x_q   <= 10'd650;
      apple_y_q   <= 10'd150;
      length_q    <= 5'd1;
      score_q     <= 8'd0;
      move_en_q   <= 1'b0;
      grow_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      attempts_q  <= attempts_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      check_q     <= check_d;
      lfsr_x_q    <= lfsr_x_d;
      lfsr_y_q    <= lfsr_y_d;
      apple_x_q   <= apple_x_d;
      apple_y_q   <= apple_y_d;
      length_q    <= length_d;
      score_q     <= score_d;
      move_en_q   <= move_en_d;
      grow_q      <= grow_d;
      game_over_q <= game_over_d;
    end
  end

  assign move_en_o   = move_en_q;
  assign dir_o       = dir_q;
  assign grow_o      = grow_q;
  assign apple_x_o   = apple_x_q;
  assign apple_y_o   = apple_y_q;
  assign length_o    = length_q;
  assign score_o     = score_q;
  assign state_o     = state_q;
  assign game_over_o = game_over_q;

endmodule
